// File: rtl/pipe_prefetch_q_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// An entry pairs the returned instruction with its PC+4.
package pipe_pkg;

   localparam logic [31:0] NOP_INST = 32'h0;
   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam int          ENTRY_W  = 64;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] inst;
   } entry_t;

endpackage

// File: rtl/pipe_prefetch_q_if.sv
// Fetch/IR side bundle of the prefetch queue.
// slave is the queue itself, master is the surrounding pipeline.
interface pipe_prefetch_q_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          imem_req;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          deq;
   logic          out_valid;
   logic [31:0]   out_pc4;
   logic [31:0]   out_inst;
   logic [CW-1:0] count;

   modport slave (
      input  redirect, redirect_pc, imem_rdata, deq,
      output imem_req, imem_addr, out_valid,
      output out_pc4, out_inst, count
   );

   modport master (
      output redirect, redirect_pc, imem_rdata, deq,
      input  imem_req, imem_addr, out_valid,
      input  out_pc4, out_inst, count
   );

endinterface

// File: rtl/pipe_prefetch_q_ram.sv
// Entry storage: one write port, one async read port.
// Storage is not reset; the top gates reads with its count.
module pipe_prefetch_ram
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  entry_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output entry_t        rdata_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = entry_t'(mem_q[raddr_i]);

endmodule

// File: rtl/pipe_prefetch_q.sv
// Prefetch queue ahead of the IF/ID register: sequential fetch,
// one-cycle memory response, flush and refetch on redirect.
module pipe_prefetch_q
   import pipe_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic               clock,
   input logic               resetn,
   pipe_prefetch_q_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc4_q, rsp_pc4_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;

   logic [CW-1:0] credit;
   logic          issue, push, pop, valid;
   entry_t        wr_entry, rd_entry;

   // Reserving a slot for the in-flight word keeps pushes from overflowing.
   assign credit = count_q + CW'(inflight_q);
   assign issue  = resetn & ~bus.redirect & (credit < CW'(DEPTH));
   assign valid  = (count_q != '0);
   assign push   = inflight_q & ~bus.redirect;
   assign pop    = bus.deq & valid & ~bus.redirect;

   assign wr_entry = '{pc4: rsp_pc4_q, inst: bus.imem_rdata};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc4_d  = rsp_pc4_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end else begin
         inflight_d = issue;
         if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            rsp_pc4_d  = fetch_pc_q + PC_STEP;
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc4_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc4_q  <= rsp_pc4_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   pipe_prefetch_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = valid;
   assign bus.out_pc4   = valid ? rd_entry.pc4 : 32'h0;
   assign bus.out_inst  = valid ? rd_entry.inst : NOP_INST;
   assign bus.count     = count_q;

endmodule
